// File: rtl/segment_display_scheduler.sv
// Time-shares one strobed 7-segment display driver between NUM_SRC producers.
// The sources take turns for a fixed dwell time, and any source can pre-empt the rotation with a queued, timed alert.
module segment_display_scheduler #(
  parameter int unsigned SEGS         = 3,
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned ALERT_CYCLES = 50000000
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_SRC-1:0]                    src_valid,
  input  logic [NUM_SRC*4*SEGS-1:0]             src_data,
  input  logic [NUM_SRC*($clog2(SEGS)+1)-1:0]   src_dp_loc,
  input  logic [NUM_SRC-1:0]                    src_dp_en,
  input  logic [NUM_SRC-1:0]                    alert_req,
  input  logic                                  freeze,
  output logic [4*SEGS-1:0]                     datain,
  output logic [$clog2(SEGS):0]                 decimal_place_location,
  output logic                                  show_decimal_place,
  output logic [$clog2(NUM_SRC)-1:0]            active_src,
  output logic                                  alert_active,
  output logic [NUM_SRC-1:0]                    alert_ack
);

  localparam int unsigned DW   = 4 * SEGS;
  localparam int unsigned LW   = $clog2(SEGS) + 1;
  localparam int unsigned IW   = $clog2(NUM_SRC);
  localparam int unsigned MAXC = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
  localparam int unsigned TW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] ALERT_LAST = TW'(ALERT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    ALERT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [IW-1:0]      active_nxt, saved_src, saved_nxt;
  logic [IW-1:0]      first_pending, after_active;
  logic [NUM_SRC-1:0] pending, ack_nxt;

  // First set bit of mask at or after start, wrapping modulo NUM_SRC.
  function automatic logic [IW-1:0] find_from(input logic [NUM_SRC-1:0] mask,
                                              input logic [IW-1:0]      start);
    logic [IW:0] idx;
    logic        hit;
    find_from = start;
    hit       = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, start} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_SRC)) idx = idx - (IW+1)'(NUM_SRC);
      if (!hit && mask[idx[IW-1:0]]) begin
        find_from = idx[IW-1:0];
        hit       = 1'b1;
      end
    end
  endfunction

  // Next-state logic: the alert queue has priority, then rotation housekeeping.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    active_nxt    = active_src;
    saved_nxt     = saved_src;
    ack_nxt       = '0;
    first_pending = find_from(pending, '0);
    after_active  = (active_src == IW'(NUM_SRC - 1)) ? '0 : active_src + IW'(1);

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (|pending) begin
          state_nxt              = ALERT;
          saved_nxt              = active_src;
          active_nxt             = first_pending;
          ack_nxt[first_pending] = 1'b1;
        end else if (|src_valid) begin
          state_nxt  = ROTATE;
          active_nxt = find_from(src_valid, '0);
        end
      end

      ROTATE: begin
        if (|pending) begin
          state_nxt              = ALERT;
          saved_nxt              = active_src;
          active_nxt             = first_pending;
          ack_nxt[first_pending] = 1'b1;
          timer_nxt              = '0;
        end else if (!(|src_valid)) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (!src_valid[active_src] || timer == DWELL_LAST) begin
          active_nxt = find_from(src_valid, after_active);
          timer_nxt  = '0;
        end else if (!freeze) begin
          timer_nxt = timer + TW'(1);
        end
      end

      ALERT: begin
        if (timer == ALERT_LAST) begin
          timer_nxt = '0;
          if (|pending) begin
            active_nxt             = first_pending;
            ack_nxt[first_pending] = 1'b1;
          end else if (|src_valid) begin
            state_nxt  = ROTATE;
            active_nxt = find_from(src_valid, saved_src);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // State, the alert queue and registered display outputs; the display follows active_src one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      timer                  <= '0;
      active_src             <= '0;
      saved_src              <= '0;
      pending                <= '0;
      alert_active           <= 1'b0;
      alert_ack              <= '0;
      datain                 <= '0;
      decimal_place_location <= '0;
      show_decimal_place     <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      active_src   <= active_nxt;
      saved_src    <= saved_nxt;
      pending      <= (pending & ~ack_nxt) | alert_req;
      alert_active <= (state_nxt == ALERT);
      alert_ack    <= ack_nxt;
      if (state == IDLE) begin
        datain                 <= '0;
        decimal_place_location <= '0;
        show_decimal_place     <= 1'b0;
      end else begin
        datain                 <= src_data[32'(active_src) * DW +: DW];
        decimal_place_location <= src_dp_loc[32'(active_src) * LW +: LW];
        show_decimal_place     <= src_dp_en[active_src];
      end
    end
  end

endmodule

// File: tb/tb_segment_display_scheduler.sv
// Checks segment_display_scheduler against a countdown-based behavioural model every cycle.
// Directed scenarios also pin run lengths and acknowledge timing with literal values.
module tb_segment_display_scheduler;

  localparam int unsigned SEGS    = 3;
  localparam int unsigned NUM_SRC = 4;
  localparam int          DWELL   = 10;
  localparam int          ALERT   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [47:0] src_data = {12'h444, 12'h333, 12'h222, 12'h111};
  logic [11:0] src_dp_loc = {3'd0, 3'd2, 3'd1, 3'd0};
  logic [3:0]  src_dp_en = 4'b0101;
  logic [3:0]  alert_req = '0;
  logic        freeze = 1'b0;
  logic [11:0] datain;
  logic [2:0]  decimal_place_location;
  logic        show_decimal_place;
  logic [1:0]  active_src;
  logic        alert_active;
  logic [3:0]  alert_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segment_display_scheduler #(
    .SEGS(SEGS), .NUM_SRC(NUM_SRC), .DWELL_CYCLES(DWELL), .ALERT_CYCLES(ALERT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_dp_loc(src_dp_loc), .src_dp_en(src_dp_en), .alert_req(alert_req),
    .freeze(freeze), .datain(datain), .decimal_place_location(decimal_place_location),
    .show_decimal_place(show_decimal_place), .active_src(active_src),
    .alert_active(alert_active), .alert_ack(alert_ack)
  );

  // Model: mode 0 idle, 1 rotate, 2 alert; m_left counts the cycles left in the current slot.
  int          m_mode = 0, m_left = 0, m_act = 0, m_saved = 0;
  logic [3:0]  m_pend = '0, m_ack = '0;
  logic [11:0] m_dat = '0;
  logic [2:0]  m_loc = '0;
  logic        m_dp = 1'b0, m_aa = 1'b0;

  function automatic int first_from(input logic [3:0] v, input int from);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (from + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return from;
  endfunction

  task automatic serve_alert();
    int a;
    a = first_from(m_pend, 0);
    m_act = a;
    m_ack[a[1:0]] = 1'b1;
    m_mode = 2;
    m_left = ALERT;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_act = 0; m_saved = 0;
      m_pend = '0; m_ack = '0; m_dat = '0; m_loc = '0; m_dp = 1'b0; m_aa = 1'b0;
    end else begin
      if (m_mode == 0) begin
        m_dat = '0; m_loc = '0; m_dp = 1'b0;
      end else begin
        m_dat = src_data[m_act*12 +: 12];
        m_loc = src_dp_loc[m_act*3 +: 3];
        m_dp  = src_dp_en[m_act];
      end
      m_ack = '0;
      case (m_mode)
        0: begin
          if (m_pend != 0) begin
            m_saved = m_act;
            serve_alert();
          end else if (src_valid != 0) begin
            m_mode = 1; m_act = first_from(src_valid, 0); m_left = DWELL;
          end
        end
        1: begin
          if (m_pend != 0) begin
            m_saved = m_act;
            serve_alert();
          end else if (src_valid == 0) begin
            m_mode = 0;
          end else if (!src_valid[m_act] || m_left == 1) begin
            m_act = first_from(src_valid, (m_act + 1) % 4); m_left = DWELL;
          end else if (!freeze) begin
            m_left--;
          end
        end
        default: begin
          if (m_left == 1) begin
            if (m_pend != 0) serve_alert();
            else if (src_valid != 0) begin
              m_mode = 1; m_act = first_from(src_valid, m_saved); m_left = DWELL;
            end else m_mode = 0;
          end else begin
            m_left--;
          end
        end
      endcase
      m_pend = (m_pend & ~m_ack) | alert_req;
      m_aa   = (m_mode == 2);
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (datain !== m_dat || decimal_place_location !== m_loc || show_decimal_place !== m_dp ||
          active_src !== 2'(m_act) || alert_active !== m_aa || alert_ack !== m_ack) begin
        errors++;
        $display("FAIL model_cmp @%0t: datain %h exp %h, loc %0d exp %0d, dp %b exp %b, src %0d exp %0d, alert %b exp %b, ack %b exp %b",
                 $time, datain, m_dat, decimal_place_location, m_loc, show_decimal_place, m_dp,
                 active_src, m_act, alert_active, m_aa, alert_ack, m_ack);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Length of the current datain run, counted in cycles from this negedge.
  task automatic measure(input string name, input logic [11:0] exp_v, input int exp_n);
    logic [11:0] v;
    int n;
    v = datain;
    n = 0;
    while (datain == v && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_val"}, 32'(v), 32'(exp_v));
    chk({name, "_len"}, n, exp_n);
  endtask

  task automatic wait_val(input string name, input logic [11:0] v);
    int n;
    n = 0;
    while (datain !== v && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(datain), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("rst_datain", 32'(datain), 0);
    chk("rst_active_src", 32'(active_src), 0);
    chk("rst_alert_active", 32'(alert_active), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_datain", 32'(datain), 0);

    // Alert from IDLE shows an invalid source, then falls back to IDLE.
    alert_req = 4'b0010;
    @(negedge clk); alert_req = '0;
    @(negedge clk);
    chk("idle_alert_ack", 32'(alert_ack), 32'h2);
    chk("idle_alert_active", 32'(alert_active), 1);
    @(negedge clk);
    measure("idle_alert", 12'h222, 6);
    chk("idle_after_alert", 32'(datain), 0);

    // Rotation over sources 0, 1, 3.
    src_valid = 4'b1011;
    wait_val("rot_start", 12'h111);
    measure("rot0", 12'h111, 10);
    chk("rot1_loc", 32'(decimal_place_location), 1);
    chk("rot1_dp", 32'(show_decimal_place), 0);
    measure("rot1", 12'h222, 10);
    measure("rot3", 12'h444, 10);
    measure("rot0b", 12'h111, 10);

    // Valid drop at dwell cycle 3 on source 1.
    repeat (2) @(negedge clk);
    src_valid = 4'b1001;
    @(negedge clk); chk("drop_hold", 32'(datain), 32'h222);
    @(negedge clk); chk("drop_next", 32'(datain), 32'h444);
    src_valid = 4'b1011;

    // Freeze on source 0.
    wait_val("freeze_start", 12'h111);
    freeze = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (datain !== 12'h111) bad++;
    end
    chk("freeze_hold_bad", bad, 0);
    freeze = 1'b0;
    measure("freeze_resume", 12'h111, 10);

    // Alert pre-empts source 1 at dwell cycle 4.
    repeat (3) @(negedge clk);
    alert_req = 4'b0100;
    @(negedge clk); alert_req = '0;
    chk("pre_ack_early", 32'(alert_ack), 0);
    @(negedge clk);
    chk("pre_ack", 32'(alert_ack), 32'h4);
    chk("pre_alert_active", 32'(alert_active), 1);
    chk("pre_src", 32'(active_src), 2);
    @(negedge clk);
    chk("pre_ack_pulse", 32'(alert_ack), 0);
    measure("pre_alert", 12'h333, 6);
    chk("pre_resume_idx", 32'(active_src), 1);
    chk("pre_resume_aa", 32'(alert_active), 0);
    measure("pre_resume", 12'h222, 10);

    // Queued alerts 0 and 3, plus 2 arriving during the first one.
    alert_req = 4'b1001;
    @(negedge clk); alert_req = '0;
    @(negedge clk);
    chk("q_ack0", 32'(alert_ack), 32'h1);
    alert_req = 4'b0100;
    @(negedge clk); alert_req = '0;
    measure("q_alert0", 12'h111, 6);
    measure("q_alert2", 12'h333, 6);
    measure("q_alert3_rot3", 12'h444, 16);
    chk("q_resume_next", 32'(datain), 32'h111);

    // Asynchronous reset mid-rotation.
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    src_valid = '0;
    #1;
    chk("async_datain", 32'(datain), 0);
    chk("async_loc", 32'(decimal_place_location), 0);
    chk("async_dp", 32'(show_decimal_place), 0);
    chk("async_active_src", 32'(active_src), 0);
    chk("async_alert_active", 32'(alert_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (datain !== 12'h000) bad++;
    end
    chk("post_rst_idle_bad", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment_display_scheduler.md
Name: segment_display_scheduler

Overview:
- Shares one 7-segment display (the strobed segment display driver) between NUM_SRC value producers, e.g. I2C status, sensor readings and error codes.
- Rotates round-robin through the valid sources, showing each for a fixed dwell time.
- Lets any source pre-empt the rotation with a timed alert.
- Drives the display driver's data, decimal-point location and decimal-point enable inputs.

Parameters:
- SEGS, 3: digits per display; each source supplies 4*SEGS bits.
- NUM_SRC, 4: number of requesting sources (2..16).
- DWELL_CYCLES, 100000000: clk cycles each source is shown during rotation (2 s at 50 MHz).
- ALERT_CYCLES, 50000000: clk cycles an alert source is held on the display.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  source i has displayable data.
- src_data  in  NUM_SRC*4*SEGS  packed data; source i occupies bits [i*4*SEGS +: 4*SEGS].
- src_dp_loc  in  NUM_SRC*($clog2(SEGS)+1)  packed decimal-point location per source; 0 is the rightmost digit.
- src_dp_en  in  NUM_SRC  decimal-point enable per source.
- alert_req  in  NUM_SRC  single-cycle alert request per source.
- freeze  in  1  holds the rotation timer while high.
- datain  out  4*SEGS  to the display driver.
- decimal_place_location  out  $clog2(SEGS)+1  to the display driver.
- show_decimal_place  out  1  to the display driver.
- active_src  out  $clog2(NUM_SRC)  index currently displayed.
- alert_active  out  1  high while in ALERT.
- alert_ack  out  NUM_SRC  one-cycle pulse on bit i when the alert for source i starts being served.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all outputs 0, timer=0.
  - Pending alerts, rotation pointer and saved pointer cleared.
- Output path:
  - All outputs are registered. In ROTATE/ALERT, datain/loc/dp at cycle t+1 equal the selected source's src_data/src_dp_loc/src_dp_en at cycle t (live tracking, 1-cycle latency).
  - In IDLE: datain=0, show_decimal_place=0, decimal_place_location=0.
- Alert capture:
  - alert_req bits are OR'd into a pending register every cycle, in any state.
  - Pending bit i is cleared on the cycle alert i is accepted (alert_ack[i]=1 that cycle).
  - A request arriving in the same cycle as its own clear stays pending.
- IDLE:
  - Pending alert present → ALERT on the lowest pending index. This takes precedence over src_valid.
  - Else any src_valid → ROTATE on the lowest valid index, timer=0.
- ROTATE:
  - Timer increments each cycle unless freeze=1.
  - Timer==DWELL_CYCLES-1: advance to the next valid index searching upward from active_src+1 with wrap; timer=0.
  - If the current source is the only valid one, it stays and the timer restarts.
  - Current source's src_valid low: advance next cycle as above, regardless of freeze or timer.
  - No source valid → IDLE.
  - Any pending alert: save active_src, then → ALERT on the lowest pending index. Alert beats dwell expiry and valid drop in the same cycle; the rotation pointer is not advanced.
- ALERT:
  - Displays the alert source regardless of its src_valid; alert_active=1; freeze is ignored.
  - Timer runs to ALERT_CYCLES-1.
  - At expiry: if alerts are pending, serve the lowest pending index next (new ack, timer=0).
  - Otherwise resume ROTATE at the saved pointer if it is still valid, else the next valid after it, with timer=0. If none valid → IDLE.
- Arithmetic:
  - Timer width is $clog2(max(DWELL_CYCLES,ALERT_CYCLES)).
  - Index arithmetic wraps modulo NUM_SRC.
- Reset asserted mid-alert or mid-dwell: immediate return to reset values; pending alerts are lost.

Test Plan:
All scenarios use SEGS=3, NUM_SRC=4, DWELL_CYCLES=10, ALERT_CYCLES=6.

1. Reset: rst_n low mid-rotation → outputs 0, active_src=0, alert_active=0 asynchronously. After release with src_valid=0, datain stays 0.
2. Rotation: src_valid=4'b1011 with data 0x111/0x222/0x333/0x444 → datain sequence 0x111, 0x222, 0x444, 0x111, each held 10 cycles; index 2 is skipped.
3. Valid drop: showing src1, deassert src_valid[1] at dwell cycle 3 → src3 (0x444) appears 2 cycles later.
4. Freeze: freeze=1 for 30 cycles on src0 → datain stays 0x111. Release → advance exactly 10 cycles after dwell resumed counting.
5. Alert pre-emption: on src1 at dwell cycle 4, pulse alert_req=4'b0100 → alert_ack=4'b0100 for 1 cycle, datain=0x333 for 6 cycles, alert_active=1. Then src1 resumes with a full 10-cycle dwell.
6. Queued alerts: alert_req=4'b1001 in one cycle, plus alert_req[2] during the first alert → alerts served in order 0, 2, 3, 6 cycles each, then rotation resumes at the saved pointer.
